// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - write-back, write-allocate N-way set-associative L1 cache controller
// Tag/valid/dirty/PLRU/data storage are internal; misses write back a dirty victim before refilling.
module cache_ctrl_wb #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            phy_addr,
    input  logic [WORD_W-1:0]            data_from_cpu,
    input  logic                         read_mem,
    input  logic                         write_mem,
    output logic [WORD_W-1:0]            data_to_cpu,
    output logic                         hit_miss,
    output logic                         ready_stall,
    output logic [ADDR_W-1:0]            main_mem_addr,
    output logic [LINE_WORDS*WORD_W-1:0] main_mem_data_out,
    output logic                         main_mem_read_req,
    output logic                         main_mem_write_req,
    input  logic [LINE_WORDS*WORD_W-1:0] main_mem_data_in,
    input  logic                         main_mem_ready
);
    localparam int LINE_W   = LINE_WORDS * WORD_W;
    localparam int BYTE_OFF = $clog2(WORD_W / 8);
    localparam int WSEL_W   = $clog2(LINE_WORDS);
    localparam int OFF      = $clog2(LINE_W / 8);
    localparam int IDX      = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - OFF - IDX;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;
    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

    state_t           r_state, w_next;
    line_t            r_data    [WAYS][SETS];
    logic [TAG_W-1:0] r_tag_mem [WAYS][SETS];
    logic [SETS-1:0]  r_valid   [WAYS];
    logic [SETS-1:0]  r_dirty   [WAYS];
    logic [2:0]       r_plru    [SETS];

    logic [IDX-1:0]    r_req_idx;
    logic [TAG_W-1:0]  r_req_tag;
    logic [WSEL_W-1:0] r_req_word;
    logic [WORD_W-1:0] r_req_wdata;
    logic              r_req_write;
    logic [WAY_W-1:0]  r_victim;
    logic [WORD_W-1:0] r_data_to_cpu;
    logic              r_hit_miss;

    logic [WSEL_W-1:0] w_word;
    logic [IDX-1:0]    w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req, w_is_write, w_hit, w_has_inv, w_victim_dirty;
    logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_victim;
    logic [1:0]        w_plru_sel;
    logic [2:0]        w_plru_bits;
    line_t             w_fill_line;
    logic              w_hit_wr, w_fill;

    assign w_word     = phy_addr[OFF-1:BYTE_OFF];
    assign w_idx      = phy_addr[OFF+IDX-1:OFF];
    assign w_tag      = phy_addr[ADDR_W-1:OFF+IDX];
    assign w_req      = read_mem | write_mem;
    assign w_is_write = write_mem & ~read_mem;

    generate
        if (BYTE_OFF > 0) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^phy_addr[BYTE_OFF-1:0];
        end
    endgenerate

    // Tree PLRU: bit0 picks the half, bit1/bit2 pick within it; for 2 ways bit0 is the LRU way.
    function automatic logic [2:0] f_plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] f;
        f = b;
        if (WAYS == 4) begin
            f[0] = ~w[1];
            if (!w[1]) f[1] = ~w[0];
            else       f[2] = ~w[0];
        end else if (WAYS == 2) begin
            f[0] = ~w[0];
        end
        return f;
    endfunction

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (r_valid[i][w_idx] && (r_tag_mem[i][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!r_valid[i][w_idx]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(i);
            end
        end
        w_plru_bits = r_plru[w_idx];
        if (WAYS == 4)      w_plru_sel = w_plru_bits[0] ? {1'b1, w_plru_bits[2]} : {1'b0, w_plru_bits[1]};
        else if (WAYS == 2) w_plru_sel = {1'b0, w_plru_bits[0]};
        else                w_plru_sel = 2'b00;
        w_victim       = w_has_inv ? w_inv_way : w_plru_sel[WAY_W-1:0];
        w_victim_dirty = !w_has_inv && r_dirty[w_victim][w_idx];
    end

    always_comb begin
        w_fill_line = main_mem_data_in;
        if (r_req_write) w_fill_line[r_req_word] = r_req_wdata;
    end

    assign w_hit_wr = !rst && (r_state == S_IDLE) && w_req && w_hit && w_is_write;
    assign w_fill   = !rst && (r_state == S_REFILL) && main_mem_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req && !w_hit) w_next = w_victim_dirty ? S_WB : S_REFILL;
            S_WB:     if (main_mem_ready) w_next = S_REFILL;
            S_REFILL: if (main_mem_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        main_mem_read_req  = 1'b0;
        main_mem_write_req = 1'b0;
        main_mem_addr      = '0;
        main_mem_data_out  = '0;
        case (r_state)
            S_WB: begin
                main_mem_write_req = 1'b1;
                main_mem_addr      = {r_tag_mem[r_victim][r_req_idx], r_req_idx, {OFF{1'b0}}};
                main_mem_data_out  = r_data[r_victim][r_req_idx];
            end
            S_REFILL: begin
                main_mem_read_req = 1'b1;
                main_mem_addr     = {r_req_tag, r_req_idx, {OFF{1'b0}}};
            end
            default: ;
        endcase
    end

    assign ready_stall = (r_state != S_IDLE);
    assign data_to_cpu = r_data_to_cpu;
    assign hit_miss    = r_hit_miss;

    // Line and tag storage keep their contents across reset; only valid/dirty/PLRU are cleared.
    always_ff @(posedge clk) begin
        if (w_hit_wr) r_data[w_hit_way][w_idx][w_word] <= data_from_cpu;
        if (w_fill) begin
            r_data[r_victim][r_req_idx]    <= w_fill_line;
            r_tag_mem[r_victim][r_req_idx] <= r_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                r_valid[i] <= '0;
                r_dirty[i] <= '0;
            end
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
            r_data_to_cpu <= '0;
            r_hit_miss    <= 1'b0;
            r_req_idx     <= '0;
            r_req_tag     <= '0;
            r_req_word    <= '0;
            r_req_wdata   <= '0;
            r_req_write   <= 1'b0;
            r_victim      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    if (w_hit) begin
                        r_hit_miss    <= 1'b1;
                        r_plru[w_idx] <= f_plru_touch(w_plru_bits, 2'(w_hit_way));
                        if (w_is_write) r_dirty[w_hit_way][w_idx] <= 1'b1;
                        else            r_data_to_cpu <= r_data[w_hit_way][w_idx][w_word];
                    end else begin
                        r_hit_miss  <= 1'b0;
                        r_req_idx   <= w_idx;
                        r_req_tag   <= w_tag;
                        r_req_word  <= w_word;
                        r_req_wdata <= data_from_cpu;
                        r_req_write <= w_is_write;
                        r_victim    <= w_victim;
                    end
                end
                S_WB: if (main_mem_ready) r_dirty[r_victim][r_req_idx] <= 1'b0;
                S_REFILL: if (main_mem_ready) begin
                    r_valid[r_victim][r_req_idx] <= 1'b1;
                    r_dirty[r_victim][r_req_idx] <= r_req_write;
                    r_plru[r_req_idx]            <= f_plru_touch(r_plru[r_req_idx], 2'(r_victim));
                    if (!r_req_write) r_data_to_cpu <= w_fill_line[r_req_word];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb/tb_cache_ctrl_wb.sv - table-driven scoreboard bench for cache_ctrl_wb
module tb_cache_ctrl_wb;
    localparam int LINE_W = 512;
    localparam int LAT    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       phy_addr;
    logic [31:0]       data_from_cpu;
    logic              read_mem, write_mem;
    logic [31:0]       data_to_cpu;
    logic              hit_miss, ready_stall;
    logic [31:0]       main_mem_addr;
    logic [LINE_W-1:0] main_mem_data_out;
    logic              main_mem_read_req, main_mem_write_req;
    logic [LINE_W-1:0] main_mem_data_in;
    logic              main_mem_ready;

    cache_ctrl_wb dut (
        .clk(clk), .rst(rst), .phy_addr(phy_addr), .data_from_cpu(data_from_cpu),
        .read_mem(read_mem), .write_mem(write_mem), .data_to_cpu(data_to_cpu),
        .hit_miss(hit_miss), .ready_stall(ready_stall), .main_mem_addr(main_mem_addr),
        .main_mem_data_out(main_mem_data_out), .main_mem_read_req(main_mem_read_req),
        .main_mem_write_req(main_mem_write_req), .main_mem_data_in(main_mem_data_in),
        .main_mem_ready(main_mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd, wr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_wb;
        logic [31:0] wb_addr;
        int          wb_word;
        logic [31:0] wb_val;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [LINE_W-1:0] mem [logic [31:0]];
    logic [31:0]       wb_addr_q[$];
    logic [LINE_W-1:0] wb_line_q[$];
    logic [31:0]       rf_addr_q[$];
    logic              both_seen = 1'b0;
    int                cnt = 0;

    function automatic vec_t mk(input logic [31:0] a, input logic rd, input logic wr,
                                input logic [31:0] wd, input logic hit, input logic chk,
                                input logic [31:0] d, input logic wb, input logic [31:0] wba,
                                input int wbw, input logic [31:0] wbv);
        vec_t v;
        v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.exp_hit = hit; v.chk_data = chk;
        v.exp_data = d; v.exp_wb = wb; v.wb_addr = wba; v.wb_word = wbw; v.wb_val = wbv;
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {16{a}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Line memory: ready pulses LAT cycles after a request is first seen, for one cycle.
    initial begin
        main_mem_ready   = 1'b0;
        main_mem_data_in = '0;
        forever begin
            @(posedge clk); #1;
            if (main_mem_read_req && main_mem_write_req) both_seen = 1'b1;
            if (main_mem_ready) begin
                main_mem_ready = 1'b0;
                cnt = 0;
            end
            if (main_mem_read_req || main_mem_write_req) begin
                if (cnt == LAT) begin
                    main_mem_ready = 1'b1;
                    cnt = 0;
                    if (main_mem_write_req) begin
                        mem[main_mem_addr] = main_mem_data_out;
                        wb_addr_q.push_back(main_mem_addr);
                        wb_line_q.push_back(main_mem_data_out);
                    end else begin
                        main_mem_data_in = mem_line(main_mem_addr);
                        rf_addr_q.push_back(main_mem_addr);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic apply(input vec_t v);
        vec_t              e;
        int                cyc;
        logic              first_req;
        logic [LINE_W-1:0] line;
        wb_addr_q.delete(); wb_line_q.delete(); rf_addr_q.delete();
        phy_addr = v.addr; read_mem = v.rd; write_mem = v.wr; data_from_cpu = v.wdata;
        sb.push_back(v);
        @(posedge clk); #1;
        read_mem = 1'b0; write_mem = 1'b0;
        first_req = v.exp_wb ? main_mem_write_req : main_mem_read_req;
        cyc = 0;
        while (ready_stall && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        chk($sformatf("hit_miss@%08h", e.addr), 32'(hit_miss), 32'(e.exp_hit));
        if (e.chk_data) chk($sformatf("data_to_cpu@%08h", e.addr), data_to_cpu, e.exp_data);
        chk($sformatf("stall_cycles@%08h", e.addr), 32'(cyc),
            e.exp_hit ? 32'd0 : 32'((LAT + 1) * (e.exp_wb ? 2 : 1)));
        if (!e.exp_hit) chk($sformatf("first_req@%08h", e.addr), 32'(first_req), 32'd1);
        chk($sformatf("wb_count@%08h", e.addr), 32'(wb_addr_q.size()), 32'(e.exp_wb));
        if (e.exp_wb && wb_addr_q.size() > 0) begin
            chk($sformatf("wb_addr@%08h", e.addr), wb_addr_q[0], e.wb_addr);
            line = wb_line_q[0];
            chk($sformatf("wb_word@%08h", e.addr), line[e.wb_word*32 +: 32], e.wb_val);
        end
        chk($sformatf("refill_count@%08h", e.addr), 32'(rf_addr_q.size()), e.exp_hit ? 32'd0 : 32'd1);
        if (!e.exp_hit && rf_addr_q.size() > 0)
            chk($sformatf("refill_addr@%08h", e.addr), rf_addr_q[0], {e.addr[31:6], 6'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; phy_addr = '0; data_from_cpu = '0; read_mem = 1'b0; write_mem = 1'b0;
        //      addr         rd wr wdata          hit chk data           wb wb_addr     w  wb_val
        vecs.push_back(mk(32'h1000, 1, 0, 32'h0,        0, 1, 32'h00001000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h1004, 1, 0, 32'h0,        1, 1, 32'h00001000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h2000, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h2000, 1, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h3000, 1, 0, 32'h0,        0, 1, 32'h00003000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h4000, 1, 0, 32'h0,        0, 1, 32'h00004000, 1, 32'h2000, 0, 32'hDEADBEEF));
        vecs.push_back(mk(32'h2000, 1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h5000, 1, 1, 32'h12345678, 0, 1, 32'h00005000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h5000, 1, 0, 32'h0,        1, 1, 32'h00005000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h6000, 1, 0, 32'h0,        0, 1, 32'h00006000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h7000, 1, 0, 32'h0,        0, 1, 32'h00007000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h7008, 0, 1, 32'hCAFEF00D, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h7008, 1, 0, 32'h0,        1, 1, 32'hCAFEF00D, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h8000, 1, 0, 32'h0,        0, 1, 32'h00008000, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h9000, 1, 0, 32'h0,        0, 1, 32'h00009000, 1, 32'h7000, 2, 32'hCAFEF00D));
        vecs.push_back(mk(32'h1040, 1, 0, 32'h0,        0, 1, 32'h00001040, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(32'h107C, 1, 0, 32'h0,        1, 1, 32'h00001040, 0, 32'h0,    0, 32'h0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_to_cpu", data_to_cpu, 32'h0);
        chk("rst_hit_miss", 32'(hit_miss), 32'd0);
        chk("rst_ready_stall", 32'(ready_stall), 32'd0);
        chk("rst_read_req", 32'(main_mem_read_req), 32'd0);
        chk("rst_write_req", 32'(main_mem_write_req), 32'd0);
        chk("rst_mem_addr", main_mem_addr, 32'h0);
        chk("rst_data_out_nonzero", 32'(main_mem_data_out != '0), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset in the middle of a refill abandons it.
        phy_addr = 32'hA000; read_mem = 1'b1;
        @(posedge clk); #1;
        read_mem = 1'b0;
        chk("midrst_read_req_up", 32'(main_mem_read_req), 32'd1);
        chk("midrst_stall_up", 32'(ready_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_read_req", 32'(main_mem_read_req), 32'd0);
        chk("midrst_write_req", 32'(main_mem_write_req), 32'd0);
        chk("midrst_ready_stall", 32'(ready_stall), 32'd0);
        chk("midrst_mem_addr", main_mem_addr, 32'h0);
        rst = 1'b0;

        apply(mk(32'h1040, 1, 0, 32'h0, 0, 1, 32'h00001040, 0, 32'h0, 0, 32'h0));
        apply(mk(32'h1000, 1, 0, 32'h0, 0, 1, 32'h00001000, 0, 32'h0, 0, 32'h0));
        apply(mk(32'h1008, 1, 0, 32'h0, 1, 1, 32'h00001000, 0, 32'h0, 0, 32'h0));

        chk("req_overlap", 32'(both_seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_wb.md
# cache_ctrl_wb

Parametrised write-back, write-allocate, N-way set-associative L1 cache controller with integrated tag, valid, dirty, pseudo-LRU and data storage. It replaces the 2-way write-through controller plus external cache memory pair, and sits between the CPU load/store port and the main memory line interface. Write hits generate no memory traffic. Dirty victims are written back as whole lines before the refill.

## Interface
- ADDR_W, 32, physical address width
- WORD_W, 32, CPU word width; multiple of 8
- LINE_WORDS, 16, words per line; power of 2; LINE_W = LINE_WORDS*WORD_W
- SETS, 64, number of sets; power of 2
- WAYS, 2, associativity; legal values 1, 2, 4
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- phy_addr  in  ADDR_W  CPU byte address
- data_from_cpu  in  WORD_W  store data
- read_mem  in  1  load request, sampled while ready_stall=0
- write_mem  in  1  store request, sampled while ready_stall=0
- data_to_cpu  out  WORD_W  load data, registered
- hit_miss  out  1  1 = last accepted request hit
- ready_stall  out  1  1 = busy with a miss, new requests ignored
- main_mem_addr  out  ADDR_W  line-aligned address
- main_mem_data_out  out  LINE_W  write-back line data
- main_mem_read_req  out  1  refill request, level
- main_mem_write_req  out  1  write-back request, level
- main_mem_data_in  in  LINE_W  refill line data, valid with main_mem_ready
- main_mem_ready  in  1  one-cycle completion pulse for the current request

## Operation
- Address split: word select = addr[OFF-1 : log2(WORD_W/8)]; index = addr[OFF+IDX-1 : OFF]; tag = remaining upper bits. OFF = log2(LINE_W/8) and IDX = log2(SETS). Byte bits below word granularity are ignored.
- States: IDLE, WB (write-back), REFILL.
- IDLE with read_mem or write_mem: latch addr, data and op. If both are asserted, it is treated as a read; the store is dropped.
- Tag compare runs in parallel over all valid ways of the set.
- Hit, read: data_to_cpu <= selected word; hit_miss <= 1. State stays IDLE.
- Hit, write: merge the word into the line; set dirty; hit_miss <= 1. State stays IDLE.
- Miss: hit_miss <= 0 and ready_stall <= 1. Select the victim:
  - the lowest-numbered invalid way, if any;
  - otherwise the PLRU way.
- If the victim is valid and dirty, go to WB. Otherwise go to REFILL.
- WB: main_mem_write_req=1; main_mem_addr={victim tag, index, 0}; main_mem_data_out=victim line. On main_mem_ready, clear dirty and go to REFILL.
- REFILL: main_mem_read_req=1; main_mem_addr={req tag, index, 0}. On main_mem_ready:
  - write main_mem_data_in into the victim way, set valid and tag;
  - for a read, data_to_cpu <= requested word and dirty=0;
  - for a write, merge data_from_cpu into the stored line and set dirty=1;
  - set ready_stall <= 0 and go to IDLE.
- PLRU update: mark the accessed way MRU on every hit and every fill.
  - WAYS=2: one bit per set.
  - WAYS=4: 3-bit tree per set.
  - WAYS=1: no state.
- At most one memory request is outstanding; read_req and write_req are never high together.

## Timing
- Reset, applied at any edge:
  - valid, dirty and PLRU cleared; state IDLE;
  - data_to_cpu=0, hit_miss=0, ready_stall=0, both memory requests 0, main_mem_addr=0, main_mem_data_out=0;
  - data array contents are not reset.
- Reset mid-miss abandons the transaction. Requests drop at the next edge; a partially written-back dirty line is lost.
- Hit latency: request sampled at edge N; data_to_cpu and hit_miss valid after edge N; ready_stall never rises.
- Miss: ready_stall, hit_miss=0 and the first memory request are all registered at edge N.
- Each request level is held until the edge that samples main_mem_ready=1, and deasserts after that edge.
- WB to REFILL: read_req rises at the same edge that write_req falls.
- Completion: ready_stall falls at the edge sampling the refill main_mem_ready. A new request is accepted from the following edge.
- main_mem_ready in IDLE is ignored.
- Total miss latency is 1 + memory latency, plus write-back latency when the victim is dirty.

## Test plan
All scenarios use default parameters (index = addr[11:6]). The memory model returns stored lines, with an initial content of {16{line address}} and 3-cycle latency.
- Read 0x1000 after reset -> read_req with addr 0x1000, no write_req, data_to_cpu=0x00001000, hit_miss=0; then read 0x1004 -> hit_miss=1, data_to_cpu=0x00001000, ready_stall stays 0.
- Write 0x2000 data 0xDEADBEEF -> miss, fills way1 with no write_req. Then read 0x2000 -> hit, 0xDEADBEEF. main_mem_write_req stays 0 throughout.
- Continue: read 0x3000 -> victim is way0 (clean 0x1000), no write_req. Then read 0x4000 -> write_req addr 0x2000 with line word0=0xDEADBEEF, then read_req 0x4000, data 0x00004000.
- Read 0x2000 again -> refill returns word0=0xDEADBEEF, proving the write-back landed.
- read_mem and write_mem high together at 0x5000 with data 0x12345678 -> treated as read. A later read of 0x5000 returns 0x00005000 and no line is dirty.
- Assert rst for one cycle mid-REFILL -> next edge: both requests 0, ready_stall=0. A re-read of 0x1000 misses.
